kyber_compress_unit: RTL and testbench

Multi-lane, runtime-configurable Kyber compress/decompress engine with a valid/ready streaming interface. Each beat carries LANES coefficients, a mode bit and a runtime bit-width d. Results are bit-exact with the Kyber reference formulas. The unit sits between the NTT/polynomial datapath and the ciphertext pack/unpack logic, and replaces the fixed-D, handshake-less compress stage.

---
 rtl/kyber_compress_unit.sv | 157 +++++++++++++++
 tb/tb_kyber_compress_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_compress_unit.sv
// rtl/kyber_compress_unit.sv - multi-lane Kyber compress/decompress pipeline with valid/ready flow control
// Optional decompress path: define KYBER_DECOMPRESS_EN to build it.
module kyber_compress_unit #(
  parameter int LANES = 4,
  parameter int Q     = 3329,
  parameter int D_MAX = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [3:0]          in_d,
  input  logic [12*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [12*LANES-1:0] out_data,
  output logic                out_mode,
  output logic [3:0]          out_d,
  output logic                out_err
);

  localparam logic [11:0] Q12    = 12'(Q);
  localparam logic [23:0] HALF_Q = 24'(Q / 2);
  // floor(2^32/Q): the quotient estimate is at most one below the true quotient
  localparam logic [31:0] RECIP  = 32'((64'd1 << 32) / 64'(Q));
  localparam logic [3:0]  DMAX4  = 4'(D_MAX);

  logic                adv;
  logic                in_err;
  logic                s1_valid, s2_valid, s3_valid;
  logic                s1_mode, s2_mode, s3_mode;
  logic                s1_err, s2_err, s3_err;
  logic [3:0]          s1_d, s2_d, s3_d;
  logic [12*LANES-1:0] lane_res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    in_err = (in_d == 4'd0) || (in_d > DMAX4);
`ifndef KYBER_DECOMPRESS_EN
    if (in_mode) in_err = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_mode   <= 1'b0;
      s2_mode   <= 1'b0;
      s3_mode   <= 1'b0;
      out_mode  <= 1'b0;
      s1_err    <= 1'b0;
      s2_err    <= 1'b0;
      s3_err    <= 1'b0;
      out_err   <= 1'b0;
      s1_d      <= 4'd0;
      s2_d      <= 4'd0;
      s3_d      <= 4'd0;
      out_d     <= 4'd0;
      out_data  <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_mode   <= in_mode;
      s1_d      <= in_d;
      s1_err    <= in_err;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_d      <= s1_d;
      s2_err    <= s1_err;
      s3_valid  <= s2_valid;
      s3_mode   <= s2_mode;
      s3_d      <= s2_d;
      s3_err    <= s2_err;
      out_valid <= s3_valid;
      out_mode  <= s3_mode;
      out_d     <= s3_d;
      out_err   <= s3_err;
      out_data  <= lane_res;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [11:0] x_in;
    logic [11:0] x_sel;
    logic [11:0] s1_x;
    logic [23:0] s2_num;
    logic [23:0] s3_num;
    logic [12:0] s3_qe;
    logic [23:0] rem;
    logic [11:0] q_fix;
    logic [11:0] mask;
    logic [11:0] r_cmp;
    logic [11:0] r_dec;

    assign x_in = in_data[12*i +: 12];

    always_comb begin
      x_sel = (x_in >= Q12) ? x_in - Q12 : x_in;
`ifdef KYBER_DECOMPRESS_EN
      if (in_mode) x_sel = x_in & 12'((13'd1 << in_d) - 13'd1);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_x   <= '0;
        s2_num <= '0;
        s3_num <= '0;
        s3_qe  <= '0;
      end else if (adv) begin
        s1_x   <= x_sel;
        s2_num <= (24'(s1_x) << s1_d) + HALF_Q;
        s3_num <= s2_num;
        s3_qe  <= 13'((56'(s2_num) * 56'(RECIP)) >> 32);
      end
    end

    // One conditional step lifts the reciprocal estimate to the exact quotient
    always_comb begin
      mask  = 12'((13'd1 << s3_d) - 13'd1);
      rem   = s3_num - 24'(s3_qe) * 24'(Q12);
      q_fix = (rem >= 24'(Q12)) ? 12'(s3_qe + 13'd1) : 12'(s3_qe);
      r_cmp = q_fix & mask;
    end

`ifdef KYBER_DECOMPRESS_EN
    logic [23:0] s2_dp;
    logic [23:0] s3_dp;
    logic [23:0] dsum;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_dp <= '0;
        s3_dp <= '0;
      end else if (adv) begin
        s2_dp <= 24'(s1_x) * 24'(Q12);
        s3_dp <= s2_dp;
      end
    end

    always_comb begin
      dsum  = s3_dp + (24'd1 << (s3_d - 4'd1));
      r_dec = 12'(dsum >> s3_d);
    end
`else
    assign r_dec = 12'd0;
`endif

    assign lane_res[12*i +: 12] = s3_err ? 12'd0 : (s3_mode ? r_dec : r_cmp);
  end

endmodule

// File: tb/tb_kyber_compress_unit.sv
// tb/tb_kyber_compress_unit.sv - self-checking bench for kyber_compress_unit
// Table vectors, stall/reset sequences, exhaustive sweep and random traffic against an arithmetic model.
module tb_kyber_compress_unit;
  localparam int LANES = 4;
  localparam int W     = 12 * LANES;
`ifdef KYBER_DECOMPRESS_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [3:0]   in_d;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_mode;
  logic [3:0]   out_d;
  logic         out_err;

  always #5 clk = ~clk;

  kyber_compress_unit #(.LANES(LANES), .Q(3329), .D_MAX(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_d      (in_d),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .out_d     (out_d),
    .out_err   (out_err)
  );

  typedef struct {
    logic [W-1:0] data;
    logic         mode;
    logic [3:0]   d;
    logic         err;
  } exp_t;

  typedef struct {
    logic         mode;
    logic [3:0]   d;
    logic [W-1:0] x;
    logic [W-1:0] r;
    logic         err;
  } vec_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [W-1:0] lanes4(int a, int b, int c, int e);
    return {12'(e), 12'(c), 12'(b), 12'(a)};
  endfunction

  function automatic logic ref_err(logic mode, logic [3:0] d);
    return (d == 4'd0) || (d > 4'd11) || (mode && !DEC_EN);
  endfunction

  function automatic logic [11:0] ref_lane(logic mode, logic [3:0] d, logic [11:0] x);
    int dd = int'(d);
    int xv = int'(x);
    int xr;
    int y;
    if (ref_err(mode, d)) return 12'd0;
    if (!mode) begin
      xr = (xv < 3329) ? xv : xv - 3329;
      return 12'(((xr * (1 << dd)) + 1664) / 3329 % (1 << dd));
    end
    y = xv % (1 << dd);
    return 12'((y * 3329 + (1 << (dd - 1))) / (1 << dd));
  endfunction

  function automatic logic [W-1:0] ref_beat(logic mode, logic [3:0] d, logic [W-1:0] data);
    logic [W-1:0] r = '0;
    for (int i = 0; i < LANES; i++) r[12*i +: 12] = ref_lane(mode, d, data[12*i +: 12]);
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data %h with no beat pending", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_mode !== e.mode || out_d !== e.d || out_err !== e.err) begin
            n_fail++;
            $display("FAIL beat: got data %h mode %0d d %0d err %0d expected data %h mode %0d d %0d err %0d",
                     out_data, out_mode, out_d, out_err, e.data, e.mode, e.d, e.err);
          end
        end
      end
    end
  endtask

  task automatic drive(logic mode, logic [3:0] d, logic [W-1:0] data, logic [W-1:0] exp_data, logic exp_err);
    int   w   = 0;
    logic acc = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_mode  = mode;
    in_d     = d;
    in_data  = data;
    while (!acc && w < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end
    in_valid = 1'b0;
    if (acc) begin
      e.data = exp_data;
      e.mode = mode;
      e.d    = d;
      e.err  = exp_err;
      sb.push_back(e);
    end else begin
      check("accept_timeout", 64'(acc), 64'd1);
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec_t         tbl[13];
    logic [3:0]   dseq[4] = '{4'd4, 4'd10, 4'd1, 4'd11};
    logic [W-1:0] exp_d;
    logic         exp_e;
    logic [W-1:0] data;
    logic         m;
    logic [3:0]   dd;
    logic [63:0]  snap;
    int           lat;
    int           bad;
    bit           done;

    tbl[0]  = '{1'b0, 4'd4,  lanes4(0, 1665, 3328, 3329),     lanes4(0, 8, 0, 0),             1'b0};
    tbl[1]  = '{1'b0, 4'd1,  lanes4(832, 833, 2497, 4095),    lanes4(0, 1, 0, 0),             1'b0};
    tbl[2]  = '{1'b0, 4'd10, lanes4(1, 2, 0, 0),              lanes4(0, 1, 0, 0),             1'b0};
    tbl[3]  = '{1'b1, 4'd4,  lanes4(8, 15, 'h018, 'hFFF),     lanes4(1665, 3121, 1665, 3121), 1'b0};
    tbl[4]  = '{1'b1, 4'd1,  lanes4(1, 0, 'hFFF, 'hFFE),      lanes4(1665, 0, 1665, 0),       1'b0};
    tbl[5]  = '{1'b1, 4'd11, lanes4(2047, 'hFFF, 'h800, 0),   lanes4(3327, 3327, 0, 0),       1'b0};
    tbl[6]  = '{1'b0, 4'd0,  lanes4(1, 2, 3, 4000),           lanes4(0, 0, 0, 0),             1'b1};
    tbl[7]  = '{1'b0, 4'd12, lanes4(1665, 3000, 7, 4095),     lanes4(0, 0, 0, 0),             1'b1};
    tbl[8]  = '{1'b0, 4'd15, lanes4(1665, 3000, 7, 4095),     lanes4(0, 0, 0, 0),             1'b1};
    tbl[9]  = '{1'b1, 4'd0,  lanes4(1, 2, 3, 4000),           lanes4(0, 0, 0, 0),             1'b1};
    tbl[10] = '{1'b1, 4'd12, lanes4(2047, 15, 1, 4095),       lanes4(0, 0, 0, 0),             1'b1};
    tbl[11] = '{1'b1, 4'd15, lanes4(2047, 15, 1, 4095),       lanes4(0, 0, 0, 0),             1'b1};
    tbl[12] = '{1'b0, 4'd4,  lanes4(1665, 1665, 0, 0),        lanes4(8, 8, 0, 0),             1'b0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_d      = 4'd0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({out_valid, out_mode, out_err, out_d, out_data}), 64'd0);
    rst_n = 1'b1;
    fork
      mon();
    join_none
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      exp_d = tbl[k].r;
      exp_e = tbl[k].err;
      if (tbl[k].mode && !DEC_EN) begin
        exp_d = '0;
        exp_e = 1'b1;
      end
      drive(tbl[k].mode, tbl[k].d, tbl[k].x, exp_d, exp_e);
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("latency", 64'(lat), 64'd3);
    end
    drain();

    fork
      begin
        for (int k = 0; k < 8; k++) begin
          m    = k[0];
          dd   = dseq[k % 4];
          data = W'({$urandom(), $urandom()});
          drive(m, dd, data, ref_beat(m, dd, data), ref_err(m, dd));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        #1;
        check("in_ready_drop", 64'(in_ready), 64'd0);
        check("stall_valid", 64'(out_valid), 64'd1);
        snap = 64'({out_valid, out_mode, out_err, out_d, out_data});
        bad  = 0;
        repeat (5) begin
          @(negedge clk);
          if (64'({out_valid, out_mode, out_err, out_d, out_data}) !== snap || in_ready !== 1'b0) bad++;
        end
        check("stall_hold", 64'(bad), 64'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int k = 0; k < 3; k++) begin
      data = W'({$urandom(), $urandom()});
      drive(1'b0, 4'd4, data, ref_beat(1'b0, 4'd4, data), 1'b0);
    end
    @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async", 64'(out_valid), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("no_stale_after_reset", 64'(bad), 64'd0);
    @(posedge clk);
    #1;

    for (int mi = 0; mi < 2; mi++) begin
      for (int d = 1; d <= 11; d++) begin
        for (int x = 0; x < 4096; x += 4) begin
          data = lanes4(x, x + 1, x + 2, x + 3);
          drive(mi[0], 4'(d), data, ref_beat(mi[0], 4'(d), data), ref_err(mi[0], 4'(d)));
        end
      end
    end
    drain();

    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          m    = 1'($urandom_range(0, 1));
          dd   = 4'($urandom_range(0, 15));
          data = W'({$urandom(), $urandom()});
          drive(m, dd, data, ref_beat(m, dd, data), ref_err(m, dd));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
